// File: rtl/spi_ahb_fifo_pkg.sv
// Shared definitions for spi_ahb_fifo: register offsets (haddr[3:2]), STATUS bit
// positions and the TX drain state machine encoding.
package spi_ahb_fifo_pkg;

    localparam logic [1:0] OFS_TXDATA = 2'd0;
    localparam logic [1:0] OFS_RXDATA = 2'd1;
    localparam logic [1:0] OFS_STATUS = 2'd2;

    localparam int STAT_TX_EMPTY     = 0;
    localparam int STAT_TX_FULL      = 1;
    localparam int STAT_RX_EMPTY     = 2;
    localparam int STAT_RX_FULL      = 3;
    localparam int STAT_BUSY         = 4;
    localparam int STAT_TX_OVF       = 5;
    localparam int STAT_RX_OVF       = 6;
    localparam int STAT_TX_COUNT_LSB = 8;
    localparam int STAT_RX_COUNT_LSB = 12;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head. A push and a pop in the same cycle
// always both complete, so the occupancy is unchanged even when full or empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (!empty || push);
    // On an empty FIFO the byte being pushed is the one popped, so forward it.
    assign rdata   = empty ? wdata : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_ahb_fifo.sv
// AHB-Lite register front end feeding an SPI core through TX/RX byte FIFOs.
// Define SPI_AHB_FIFO_IRQ_EN to add the irq output.
module spi_ahb_fifo
    import spi_ahb_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hsel,
    input  logic         hwrite,
    input  logic [31:0]  haddr,
    input  logic [31:0]  hwdata,
    output logic [31:0]  hrdata,
    output logic [7:0]   spi_data_in,
    output logic         spi_ready_send,
    input  logic         spi_busy,
    input  logic [7:0]   spi_data_out,
    output drain_state_t fsm_state
`ifdef SPI_AHB_FIFO_IRQ_EN
    ,
    output logic         irq
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic           a_sel;
    logic           a_write;
    logic [1:0]     a_ofs;
    logic           wr_tx;
    logic           rd_rx;
    logic           wr_status;
    logic           rd_status;

    logic           tx_pop;
    logic [7:0]     tx_head;
    logic           tx_full;
    logic           tx_empty;
    logic [CW-1:0]  tx_count;
    logic           rx_push;
    logic           rx_pop;
    logic [7:0]     rx_head;
    logic           rx_full;
    logic           rx_empty;
    logic [CW-1:0]  rx_count;

    logic           tx_ovf;
    logic           rx_ovf;
    logic [31:0]    status;
    logic [7:0]     data_reg;
    drain_state_t   state;
    drain_state_t   state_next;
    logic           unused_bits;

    assign unused_bits = ^{haddr[31:4], haddr[1:0], hwdata[31:8]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sel   <= 1'b0;
            a_write <= 1'b0;
            a_ofs   <= '0;
        end else begin
            a_sel   <= hsel;
            a_write <= hwrite;
            a_ofs   <= haddr[3:2];
        end
    end

    assign wr_tx     = a_sel &&  a_write && (a_ofs == OFS_TXDATA);
    assign rd_rx     = a_sel && !a_write && (a_ofs == OFS_RXDATA);
    assign wr_status = a_sel &&  a_write && (a_ofs == OFS_STATUS);
    assign rd_status = a_sel && !a_write && (a_ofs == OFS_STATUS);
    // An empty RX read is a no-op: no pop, no flag change.
    assign rx_pop    = rd_rx && !rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx),
        .pop   (tx_pop),
        .wdata (hwdata[7:0]),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (spi_data_out),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        tx_pop         = 1'b0;
        rx_push        = 1'b0;
        spi_ready_send = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!tx_empty && !spi_busy) begin
                    tx_pop     = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                spi_ready_send = 1'b1;
                state_next     = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (spi_busy) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!spi_busy) begin
                    rx_push    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The byte is latched on the TX pop and held until the next transfer starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg <= '0;
        end else if (tx_pop) begin
            data_reg <= tx_head;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (wr_status && hwdata[STAT_TX_OVF]) begin
                tx_ovf <= 1'b0;
            end
            if (wr_status && hwdata[STAT_RX_OVF]) begin
                rx_ovf <= 1'b0;
            end
            // A new overflow in the clearing cycle wins over the clear.
            if (wr_tx && tx_full && !tx_pop) begin
                tx_ovf <= 1'b1;
            end
            if (rx_push && rx_full && !rx_pop) begin
                rx_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        status                                = '0;
        status[STAT_TX_EMPTY]                 = tx_empty;
        status[STAT_TX_FULL]                  = tx_full;
        status[STAT_RX_EMPTY]                 = rx_empty;
        status[STAT_RX_FULL]                  = rx_full;
        status[STAT_BUSY]                     = (state != S_IDLE);
        status[STAT_TX_OVF]                   = tx_ovf;
        status[STAT_RX_OVF]                   = rx_ovf;
        status[STAT_TX_COUNT_LSB +: 4]        = 4'(tx_count);
        status[STAT_RX_COUNT_LSB +: 4]        = 4'(rx_count);
    end

    always_comb begin
        hrdata = '0;
        if (rx_pop) begin
            hrdata = {24'h0, rx_head};
        end else if (rd_status) begin
            hrdata = status;
        end
    end

    assign spi_data_in = data_reg;
    assign fsm_state   = state;

`ifdef SPI_AHB_FIFO_IRQ_EN
    assign irq = (rx_count != '0) || tx_ovf || rx_ovf;
`endif

endmodule

// File: tb/tb_spi_ahb_fifo.sv
// Randomized bench for spi_ahb_fifo with a behavioural SPI core and queue-based
// reference of the TX/RX FIFOs and sticky flags.
`timescale 1ns/1ps
module tb_spi_ahb_fifo;
    import spi_ahb_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] A_TX  = 32'h0;
    localparam logic [31:0] A_RX  = 32'h4;
    localparam logic [31:0] A_ST  = 32'h8;
    localparam logic [31:0] A_UNM = 32'hC;

    logic         clk;
    logic         rst;
    logic         hsel;
    logic         hwrite;
    logic [31:0]  haddr;
    logic [31:0]  hwdata;
    logic [31:0]  hrdata;
    logic [7:0]   spi_data_in;
    logic         spi_ready_send;
    logic         spi_busy;
    logic [7:0]   spi_data_out;
    drain_state_t fsm_state;
`ifdef SPI_AHB_FIFO_IRQ_EN
    logic         irq;
`endif

    logic stall_busy;
    logic xfer_busy;
    assign spi_busy = stall_busy | xfer_busy;

    int checks;
    int errors;
    int pulses;
    int xfers_done;
    int busy_len_min;
    int busy_len_max;

    logic [7:0]  miso_q[$];
    logic [7:0]  sent_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_tx_q[$];
    logic        ref_tx_ovf;
    logic        ref_rx_ovf;
    logic [7:0]  model_byte;
    logic [7:0]  exp_b;
    logic [7:0]  got_b;
    logic [31:0] rd;
    logic [31:0] exp_w;

    spi_ahb_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .hsel           (hsel),
        .hwrite         (hwrite),
        .haddr          (haddr),
        .hwdata         (hwdata),
        .hrdata         (hrdata),
        .spi_data_in    (spi_data_in),
        .spi_ready_send (spi_ready_send),
        .spi_busy       (spi_busy),
        .spi_data_out   (spi_data_out),
        .fsm_state      (fsm_state)
`ifdef SPI_AHB_FIFO_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (spi_ready_send === 1'b1) pulses++;
    end

    // SPI core: answers each start pulse with a busy window and a MISO byte.
    initial begin
        xfer_busy    = 1'b0;
        spi_data_out = '0;
        forever begin
            @(negedge clk);
            if (spi_ready_send === 1'b1) begin
                sent_q.push_back(spi_data_in);
                repeat ($urandom_range(1, 2)) @(negedge clk);
                if (miso_q.size() != 0) model_byte = miso_q.pop_front();
                else model_byte = 8'($urandom);
                spi_data_out = model_byte;
                xfer_busy    = 1'b1;
                repeat ($urandom_range(busy_len_min, busy_len_max)) @(negedge clk);
                xfer_busy = 1'b0;
                if (exp_q.size() >= DEPTH) ref_rx_ovf = 1'b1;
                else exp_q.push_back(model_byte);
                xfers_done++;
            end
        end
    end

    function automatic logic [31:0] ref_status(input int txc, input int rxc, input int busy,
                                               input logic txo, input logic rxo);
        int s;
        s = int'(txc == 0) + 2 * int'(txc == DEPTH) + 4 * int'(rxc == 0) + 8 * int'(rxc == DEPTH)
            + 16 * busy + 32 * int'(txo) + 64 * int'(rxo) + 256 * txc + 4096 * rxc;
        return 32'(s);
    endfunction

    // Driver tasks
    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        hsel = 1'b1; hwrite = 1'b1; haddr = addr;
        @(negedge clk);
        hsel = 1'b0; hwrite = 1'b0; hwdata = data;
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        hsel = 1'b1; hwrite = 1'b0; haddr = addr;
        @(negedge clk);
        hsel = 1'b0;
        data = hrdata;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (!(xfers_done >= target && fsm_state == S_IDLE && spi_busy == 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_drain_timeout: transfers %0d required %0d", name, xfers_done, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        hsel = 1'b1; hwrite = 1'b0; haddr = A_ST;
        repeat (2) @(negedge clk);
        checks++;
        if (hrdata !== 32'h0) begin
            errors++; $display("FAIL reset_hrdata: got %h required %h", hrdata, 32'h0);
        end
        checks++;
        if (spi_data_in !== 8'h0 || spi_ready_send !== 1'b0) begin
            errors++; $display("FAIL reset_spi_out: got %h/%b required 00/0", spi_data_in, spi_ready_send);
        end
        checks++;
        if (fsm_state !== S_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d required %0d", fsm_state, S_IDLE);
        end
        hsel = 1'b0;
        rst  = 1'b1;
        ahb_read(A_ST, rd);
        exp_w = ref_status(0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (rd !== exp_w) begin
            errors++; $display("FAIL reset_status: got %h required %h", rd, exp_w);
        end
`ifdef SPI_AHB_FIFO_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq: got %b required 0", irq);
        end
`endif
    endtask

    task automatic test_single();
        int p0;
        int x0;
        p0 = pulses;
        x0 = xfers_done;
        miso_q.push_back(8'h37);
        exp_tx_q.push_back(8'h13);
        ahb_write(A_TX, 32'h0000_0013);
        wait_done(x0 + 1, "single");
        checks++;
        if (pulses - p0 !== 1) begin
            errors++; $display("FAIL single_pulses: got %0d required 1", pulses - p0);
        end
        checks++;
        if (spi_data_in !== 8'h13) begin
            errors++; $display("FAIL single_data_in: got %h required 13", spi_data_in);
        end
        while (exp_tx_q.size() != 0) begin
            exp_b = exp_tx_q.pop_front();
            got_b = 8'hxx;
            if (sent_q.size() != 0) got_b = sent_q.pop_front();
            checks++;
            if (got_b !== exp_b) begin
                errors++; $display("FAIL single_sent: got %h required %h", got_b, exp_b);
            end
        end
`ifdef SPI_AHB_FIFO_IRQ_EN
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL single_irq_rise: got %b required 1", irq);
        end
`endif
        ahb_read(A_RX, rd);
        exp_w = 32'h0;
        if (exp_q.size() != 0) exp_w = {24'h0, exp_q.pop_front()};
        checks++;
        if (rd !== exp_w) begin
            errors++; $display("FAIL single_rxdata: got %h required %h", rd, exp_w);
        end
        ahb_read(A_ST, rd);
        exp_w = ref_status(0, exp_q.size(), 0, ref_tx_ovf, ref_rx_ovf);
        checks++;
        if (rd !== exp_w) begin
            errors++; $display("FAIL single_status: got %h required %h", rd, exp_w);
        end
`ifdef SPI_AHB_FIFO_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL single_irq_fall: got %b required 0", irq);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int x0;
        int n_acc;
        x0 = xfers_done;
        stall_busy = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                hwdata = {24'h0, 8'hA0 + 8'(i - 1)};
                if (exp_tx_q.size() >= DEPTH) ref_tx_ovf = 1'b1;
                else exp_tx_q.push_back(8'hA0 + 8'(i - 1));
            end
            if (i < 5) begin
                hsel = 1'b1; hwrite = 1'b1; haddr = A_TX;
            end else begin
                hsel = 1'b0; hwrite = 1'b0;
            end
        end
        n_acc = exp_tx_q.size();
        ahb_read(A_ST, rd);
        exp_w = ref_status(n_acc, exp_q.size(), 0, ref_tx_ovf, ref_rx_ovf);
        checks++;
        if (rd !== exp_w) begin
            errors++; $display("FAIL b2b_status_full: got %h required %h", rd, exp_w);
        end
        @(negedge clk);
        stall_busy = 1'b0;
        wait_done(x0 + n_acc, "b2b");
        while (exp_tx_q.size() != 0) begin
            exp_b = exp_tx_q.pop_front();
            got_b = 8'hxx;
            if (sent_q.size() != 0) got_b = sent_q.pop_front();
            checks++;
            if (got_b !== exp_b) begin
                errors++; $display("FAIL b2b_sent: got %h required %h", got_b, exp_b);
            end
        end
        ahb_write(A_ST, 32'h0000_0020);
        ref_tx_ovf = 1'b0;
        ahb_read(A_ST, rd);
        exp_w = ref_status(0, exp_q.size(), 0, ref_tx_ovf, ref_rx_ovf);
        checks++;
        if (rd !== exp_w) begin
            errors++; $display("FAIL b2b_status_clear: got %h required %h", rd, exp_w);
        end
        while (exp_q.size() != 0) begin
            ahb_read(A_RX, rd);
            exp_w = {24'h0, exp_q.pop_front()};
            checks++;
            if (rd !== exp_w) begin
                errors++; $display("FAIL b2b_rxdata: got %h required %h", rd, exp_w);
            end
        end
    endtask

    task automatic test_rx_overflow();
        int x0;
        logic [7:0] b;
        x0 = xfers_done;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            exp_tx_q.push_back(b);
            ahb_write(A_TX, {24'h0, b});
            wait_done(x0 + i + 1, "rxovf");
        end
        ahb_read(A_ST, rd);
        exp_w = ref_status(0, exp_q.size(), 0, ref_tx_ovf, ref_rx_ovf);
        checks++;
        if (rd !== exp_w) begin
            errors++; $display("FAIL rxovf_status: got %h required %h", rd, exp_w);
        end
        ahb_write(A_ST, 32'h0000_0040);
        ref_rx_ovf = 1'b0;
        ahb_read(A_ST, rd);
        exp_w = ref_status(0, exp_q.size(), 0, ref_tx_ovf, ref_rx_ovf);
        checks++;
        if (rd !== exp_w) begin
            errors++; $display("FAIL rxovf_status_clear: got %h required %h", rd, exp_w);
        end
        while (exp_tx_q.size() != 0) begin
            exp_b = exp_tx_q.pop_front();
            got_b = 8'hxx;
            if (sent_q.size() != 0) got_b = sent_q.pop_front();
            checks++;
            if (got_b !== exp_b) begin
                errors++; $display("FAIL rxovf_sent: got %h required %h", got_b, exp_b);
            end
        end
        while (exp_q.size() != 0) begin
            ahb_read(A_RX, rd);
            exp_w = {24'h0, exp_q.pop_front()};
            checks++;
            if (rd !== exp_w) begin
                errors++; $display("FAIL rxovf_rxdata: got %h required %h", rd, exp_w);
            end
        end
    endtask

    task automatic test_rx_empty();
        ahb_read(A_RX, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL empty_rxdata: got %h required %h", rd, 32'h0);
        end
        ahb_write(A_RX, 32'h0000_00FF);
        ahb_read(A_TX, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL txdata_read: got %h required %h", rd, 32'h0);
        end
        ahb_read(A_UNM, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL unmapped_read: got %h required %h", rd, 32'h0);
        end
        ahb_read(A_ST, rd);
        exp_w = ref_status(0, 0, 0, ref_tx_ovf, ref_rx_ovf);
        checks++;
        if (rd !== exp_w) begin
            errors++; $display("FAIL empty_status: got %h required %h", rd, exp_w);
        end
    endtask

    task automatic test_random();
        int n;
        int k;
        int x0;
        logic [7:0] b;
        for (int r = 0; r < 4; r++) begin
            n  = $urandom_range(1, DEPTH);
            x0 = xfers_done;
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                exp_tx_q.push_back(b);
                ahb_write(A_TX, {24'h0, b});
            end
            wait_done(x0 + n, "random");
            while (exp_tx_q.size() != 0) begin
                exp_b = exp_tx_q.pop_front();
                got_b = 8'hxx;
                if (sent_q.size() != 0) got_b = sent_q.pop_front();
                checks++;
                if (got_b !== exp_b) begin
                    errors++; $display("FAIL random_sent: got %h required %h", got_b, exp_b);
                end
            end
            k = $urandom_range(0, n);
            for (int j = 0; j < k; j++) begin
                ahb_read(A_RX, rd);
                exp_w = 32'h0;
                if (exp_q.size() != 0) exp_w = {24'h0, exp_q.pop_front()};
                checks++;
                if (rd !== exp_w) begin
                    errors++; $display("FAIL random_rxdata: got %h required %h", rd, exp_w);
                end
            end
            ahb_read(A_ST, rd);
            exp_w = ref_status(0, exp_q.size(), 0, ref_tx_ovf, ref_rx_ovf);
            checks++;
            if (rd !== exp_w) begin
                errors++; $display("FAIL random_status: got %h required %h", rd, exp_w);
            end
        end
        while (exp_q.size() != 0) begin
            ahb_read(A_RX, rd);
            exp_w = {24'h0, exp_q.pop_front()};
            checks++;
            if (rd !== exp_w) begin
                errors++; $display("FAIL random_drain: got %h required %h", rd, exp_w);
            end
        end
        ahb_write(A_ST, 32'h0000_0060);
        ref_tx_ovf = 1'b0;
        ref_rx_ovf = 1'b0;
    endtask

    task automatic test_reset_mid();
        int x0;
        int p0;
        int n;
        logic [7:0] b;
        busy_len_min = 30;
        busy_len_max = 30;
        x0 = xfers_done;
        b  = 8'($urandom_range(1, 255));
        ahb_write(A_TX, {24'h0, b});
        n = 0;
        while (fsm_state != S_WAIT_DONE && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++; $display("FAIL mid_reach_wait_done: got state %0d required %0d", fsm_state, S_WAIT_DONE);
        end
        ahb_read(A_ST, rd);
        exp_w = ref_status(0, 0, 1, 1'b0, 1'b0);
        checks++;
        if (rd !== exp_w) begin
            errors++; $display("FAIL mid_status_busy: got %h required %h", rd, exp_w);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (fsm_state !== S_IDLE || spi_ready_send !== 1'b0) begin
            errors++; $display("FAIL mid_reset_fsm: got %0d/%b required %0d/0", fsm_state, spi_ready_send, S_IDLE);
        end
        checks++;
        if (spi_data_in !== 8'h0 || hrdata !== 32'h0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h/%h required 00/00000000", spi_data_in, hrdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        p0 = pulses;
        n  = 0;
        while (!(xfers_done >= x0 + 1 && spi_busy == 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        exp_q.delete();
        sent_q.delete();
        ref_tx_ovf = 1'b0;
        ref_rx_ovf = 1'b0;
        ahb_read(A_ST, rd);
        exp_w = ref_status(0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (rd !== exp_w) begin
            errors++; $display("FAIL mid_status_after: got %h required %h", rd, exp_w);
        end
        ahb_read(A_RX, rd);
        checks++;
        if (rd !== 32'h0 || pulses != p0) begin
            errors++; $display("FAIL mid_rx_discard: got %h pulses %0d required 00000000 pulses %0d", rd, pulses, p0);
        end
        busy_len_min = 1;
        busy_len_max = 4;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        pulses       = 0;
        xfers_done   = 0;
        busy_len_min = 1;
        busy_len_max = 4;
        stall_busy   = 1'b0;
        ref_tx_ovf   = 1'b0;
        ref_rx_ovf   = 1'b0;
        rst          = 1'b0;
        hsel         = 1'b0;
        hwrite       = 1'b0;
        haddr        = '0;
        hwdata       = '0;

        test_reset();
        test_single();
        test_back_to_back();
        test_rx_overflow();
        test_rx_empty();
        test_random();
        test_reset_mid();

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
